spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//  SPI mode-0 responder: the target end of the spi master link (spi_cs_l/spi_clk/spi_data).
//  Samples MOSI and drives MISO, MSB first, one WIDTH-bit word per chip-select frame.
//  The external SPI pins are asynchronous to clk and are oversampled in the clk domain.
//  The local side exchanges words through a tx buffer and an rx register, each with a handshake.
// PARAMETERS
//  WIDTH        16  bits per frame
//  SYNC_STAGES  2   synchronizer flops per SPI input (>=2)
// PORTS
//  clk        in   1       system clock; all logic is on posedge clk
//  reset      in   1       synchronous, active-high reset
//  spi_cs_l   in   1       chip select, active low (async)
//  spi_clk    in   1       SPI clock, idle low (async); f(spi_clk) <= f(clk)/8
//  spi_mosi   in   1       master-out data (async)
//  spi_miso   out  1       slave-out data
//  tx_data    in   WIDTH   word to return in the next frame
//  tx_load    in   1       writes tx_data to the tx buffer when tx_ready=1; ignored otherwise
//  tx_ready   out  1       tx buffer empty
//  rx_data    out  WIDTH   last complete received word
//  rx_valid   out  1       rx_data holds an unread word
//  rx_ack     in   1       consumes rx_data; clears rx_valid and overrun
//  overrun    out  1       sticky: a frame completed while rx_valid=1
//  counter    out  clog2(WIDTH)+1  bits remaining in the current frame (WIDTH when idle)
// BEHAVIOUR
//  Reset: spi_miso=0, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, counter=WIDTH, state=IDLE;
//   tx buffer, shift registers and synchronizers are cleared. A reset mid-frame drops the frame.
//  Inputs pass SYNC_STAGES flops plus one history flop; edges (cs fall/rise, sclk rise/fall)
//   are single-cycle pulses from the compare. Pin-to-detect latency is SYNC_STAGES+1 clk.
//  FSM:
//   IDLE : on cs fall -> tx_shift <= tx buffer (or tx_data when tx_load in the same cycle;
//          0 when the buffer is empty), buffer marked empty (tx_ready=1), counter=WIDTH -> SHIFT.
//   SHIFT: sclk rise -> rx_shift <= {rx_shift[WIDTH-2:0], mosi}; counter-1.
//          sclk fall with counter>0 -> tx_shift <= tx_shift<<1.
//          counter reaches 0 -> rx_data <= assembled word; rx_valid=1; overrun=1 if rx_valid
//           was already 1 (new word overwrites the old one) -> DONE.
//          cs rise before counter=0 -> partial word discarded, no rx_valid -> IDLE.
//   DONE : extra sclk edges are ignored; cs rise -> counter=WIDTH -> IDLE.
//  spi_miso = tx_shift[WIDTH-1] while in SHIFT/DONE, else 0. It is stable before the first
//   rising sclk as long as cs-to-sclk >= SYNC_STAGES+2 clk.
//  rx_ack has priority over setting rx_valid/overrun only when no frame completes in the same
//   cycle; completion and rx_ack together -> rx_valid=1, overrun=0.
//  tx_load when tx_ready=1 -> buffer full, tx_ready=0 next cycle. A second load is dropped.
//  Simultaneous cs fall and cs rise cannot occur. sclk edges in IDLE are ignored.
// STRUCTURE
//  Package spi_pkg: SPI_WORD=16 and the state enum (IDLE, SHIFT, DONE), 2-bit encoding
//   matching the master (00 idle).
//  Sub-module spi_sync: SYNC_STAGES flop chain + history flop; outputs level, rise, fall.
//   It is instantiated once each for cs, sclk and mosi (mosi uses level only).
// TESTING
//  1) tx_load 16'hA5C3, master sends 16'h1234 at clk/8 -> rx_data=16'h1234, rx_valid pulses
//     then holds, MISO stream = 16'hA5C3, tx_ready returns to 1 at the cs fall.
//  2) No tx_load, master sends 16'hFFFF -> MISO all 0, rx_data=16'hFFFF.
//  3) cs rises after 7 bits -> rx_valid stays 0, counter=16, next full frame 16'h0F0F received.
//  4) Two frames with no rx_ack -> overrun=1, rx_data = second word; rx_ack clears both.
//  5) tx_load in the same cycle as the detected cs fall -> that tx_data is sent in this frame.
//  6) reset asserted mid-frame after 9 bits -> all outputs at reset values; next frame is correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI link: word size and the frame state encoding.
package spi_pkg;

  localparam int SPI_WORD = 16;

  // Encoding matches the master side so both ends report the same state codes.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Brings one asynchronous SPI pin into the clk domain and flags its edges.
// level appears SYNC_STAGES clk after the pin; rise/fall are one-cycle pulses.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 target: one WIDTH-bit word per chip-select frame, MSB first, pins oversampled in clk.
// Local side: single-entry tx buffer (tx_load/tx_ready) and rx register (rx_valid/rx_ack, sticky overrun).
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WORD,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_cs_l,
  input  logic                     spi_clk,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  input  logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_load,
  output logic                     tx_ready,
  output logic [WIDTH-1:0]         rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ack,
  output logic                     overrun,
  output logic [$clog2(WIDTH):0]   counter
);

  localparam int CW = $clog2(WIDTH) + 1;

  spi_state_t       state;
  logic [WIDTH-1:0] tx_buf;
  logic             tx_full;
  logic [WIDTH-2:0] tx_shift;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] tx_next;

  logic cs_level_unused, cs_rise, cs_fall;
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset(reset), .din(spi_cs_l),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(spi_clk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(spi_mosi),
    .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // A load arriving on the very cycle the frame starts goes straight onto the wire.
  assign tx_next  = tx_full ? tx_buf : (tx_load ? tx_data : '0);
  assign tx_ready = ~tx_full;

  // spi_miso is the MSB of the outgoing word; tx_shift holds the bits still to follow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= CW'(WIDTH);
      tx_buf   <= '0;
      tx_full  <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      spi_miso <= 1'b0;
    end else begin
      if (tx_load && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end
      if (rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            spi_miso <= tx_next[WIDTH-1];
            tx_shift <= tx_next[WIDTH-2:0];
            tx_full  <= 1'b0;
            counter  <= CW'(WIDTH);
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            counter  <= CW'(WIDTH);
            spi_miso <= 1'b0;
            state    <= IDLE;
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[WIDTH-3:0], mosi};
              counter  <= counter - CW'(1);
              if (counter == CW'(1)) begin
                rx_data  <= {rx_shift, mosi};
                rx_valid <= 1'b1;
                // A simultaneous ack consumes the old word, so no overrun is flagged.
                overrun  <= (overrun | rx_valid) & ~rx_ack;
                state    <= DONE;
              end
            end
            if (sclk_fall && counter != '0) begin
              spi_miso <= tx_shift[WIDTH-2];
              tx_shift <= {tx_shift[WIDTH-3:0], 1'b0};
            end
          end
        end

        DONE: begin
          if (cs_rise) begin
            counter  <= CW'(WIDTH);
            spi_miso <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
